// File: rtl/dac_spi_pkg.sv
// Shared definitions for the SPI DAC transmitter: FSM state encoding and SPI phase constants.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    LDAC
  } state_e;

  // CPHA values: where the receiving DAC samples relative to the frame's first clock edge.
  localparam bit CPHA_LEADING  = 1'b0;
  localparam bit CPHA_TRAILING = 1'b1;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timebase: counts CLK_DIV system cycles and emits a one-cycle tick on the last one.
module spi_half_tick #(
  parameter int CLK_DIV = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear || count == LAST) count <= '0;
    else                                      count <= count + 1'b1;
  end

  assign o_tick = !i_clear && (count == LAST);

endmodule

// File: rtl/dac_spi_multi.sv
// Multi-channel SPI DAC transmitter: one CS frame per enabled channel, then a shared LDAC pulse.
module dac_spi_multi
  import dac_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 2,
  parameter int CLK_DIV    = 10,
  parameter bit CPOL       = 1'b1,
  parameter bit CPHA       = 1'b0,
  parameter int CS_GAP     = 2
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]            i_channel_mask,
  input  logic                           i_send,
  output logic                           o_Ready,
  output logic                           o_Done,
  output logic                           o_SPI_CS,
  output logic                           o_SPI_clock,
  output logic                           o_SPI_data,
  output logic                           o_LDAC
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  state_e                         state, next_state;
  logic                           tick;
  logic [CHANNELS*DATA_WIDTH-1:0] data_q, scan_data;
  logic [CHANNELS-1:0]            pending, scan_mask, first_oh;
  logic [DATA_WIDTH-1:0]          first_word, shift_q;
  logic [BIT_W-1:0]               bit_cnt;
  logic [GAP_W-1:0]               gap_cnt;
  logic                           accept, leading, shift_done, gap_done, toggle, enter_setup;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (state == IDLE),
    .o_tick  (tick)
  );

  assign accept      = i_send && o_Ready && (|i_channel_mask);
  assign leading     = (o_SPI_clock == CPOL);
  // The 2*DATA_WIDTH-th half-period ends with the clock back at idle and all trailing edges issued.
  assign shift_done  = leading && (bit_cnt == BIT_W'(DATA_WIDTH));
  assign gap_done    = (gap_cnt == GAP_W'(CS_GAP - 1));
  assign toggle      = tick && ((state == SETUP) || (state == SHIFT && !shift_done));
  assign enter_setup = (next_state == SETUP) && (state != SETUP);

  // Lowest-index pending channel; on the accepting cycle the scan looks at the live inputs.
  always_comb begin
    scan_mask  = (state == IDLE) ? i_channel_mask : pending;
    scan_data  = (state == IDLE) ? i_data : data_q;
    first_oh   = scan_mask & (~scan_mask + 1'b1);
    first_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (first_oh[c]) first_word = scan_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)                next_state = SETUP;
      SETUP:   if (tick)                  next_state = SHIFT;
      SHIFT:   if (tick && shift_done)    next_state = HOLD;
      HOLD:    if (tick)                  next_state = GAP;
      GAP:     if (tick && gap_done)      next_state = (|pending) ? SETUP : LDAC;
      LDAC:    if (tick)                  next_state = IDLE;
      default:                            next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_SPI_CS    <= 1'b1;
      o_SPI_clock <= CPOL;
      o_SPI_data  <= 1'b0;
      o_LDAC      <= 1'b1;
      o_Ready     <= 1'b1;
      o_Done      <= 1'b0;
      data_q      <= '0;
      pending     <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      o_Done <= 1'b0;
      if (accept) begin
        data_q  <= i_data;
        o_Ready <= 1'b0;
      end
      if (enter_setup) begin
        o_SPI_CS <= 1'b0;
        pending  <= scan_mask & ~first_oh;
        bit_cnt  <= '0;
        if (CPHA == CPHA_LEADING) begin
          o_SPI_data <= first_word[DATA_WIDTH-1];
          shift_q    <= first_word << 1;
        end else begin
          shift_q    <= first_word;
        end
      end
      if (toggle) begin
        o_SPI_clock <= ~o_SPI_clock;
        if (leading) begin
          if (CPHA == CPHA_TRAILING) begin
            o_SPI_data <= shift_q[DATA_WIDTH-1];
            shift_q    <= shift_q << 1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          // The last bit stays on the line after its final sampling edge until the frame closes.
          if (CPHA == CPHA_LEADING && bit_cnt != BIT_W'(DATA_WIDTH - 1)) begin
            o_SPI_data <= shift_q[DATA_WIDTH-1];
            shift_q    <= shift_q << 1;
          end
        end
      end
      if (state == HOLD && tick) begin
        o_SPI_CS   <= 1'b1;
        o_SPI_data <= 1'b0;
        gap_cnt    <= '0;
      end
      if (state == GAP && tick)       gap_cnt <= gap_cnt + 1'b1;
      if (state == GAP && next_state == LDAC) o_LDAC <= 1'b0;
      if (state == LDAC && tick) begin
        o_LDAC  <= 1'b1;
        o_Done  <= 1'b1;
        o_Ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench: four instances (one per CPOL/CPHA mode) share stimulus; a monitor decodes each bus.
module tb_dac_spi_multi;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [1:0]  mask;
  logic        send_req;
  logic        mon_clear;
  logic [3:0]  cs, sclk, sdo, ldac, ready, done;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance m runs with CPOL = m[1], CPHA = m[0]; instance 2 is CPOL=1, CPHA=0.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dac_spi_multi #(
      .DATA_WIDTH (8),
      .CHANNELS   (2),
      .CLK_DIV    (2),
      .CPOL       (g >= 2),
      .CPHA       ((g % 2) == 1),
      .CS_GAP     (2)
    ) u_dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_data         (data),
      .i_channel_mask (mask),
      .i_send         (send_req),
      .o_Ready        (ready[g]),
      .o_Done         (done[g]),
      .o_SPI_CS       (cs[g]),
      .o_SPI_clock    (sclk[g]),
      .o_SPI_data     (sdo[g]),
      .o_LDAC         (ldac[g])
    );
  end

  int         busy[4], done_cnt[4], ldac_low[4], nframes[4], gap_len[4];
  int         idle_bad[4], glitch_bad[4], sdo_bad[4], cs_run[4], hi_run[4], rx_bits[4];
  int         flen[4][4], fbits[4][4];
  logic [7:0] rx[4];
  logic [7:0] fword[4][4];
  logic [3:0] prev_sclk, prev_cs;

  function automatic bit is_sample_edge(int m, logic s);
    bit cpol = (m >= 2);
    bit cpha = ((m % 2) == 1);
    return cpha ? (s == cpol) : (s != cpol);
  endfunction

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (mon_clear) begin
        busy[m] = 0; done_cnt[m] = 0; ldac_low[m] = 0; nframes[m] = 0; gap_len[m] = 0;
        idle_bad[m] = 0; glitch_bad[m] = 0; sdo_bad[m] = 0; cs_run[m] = 0; hi_run[m] = 0;
        rx_bits[m] = 0; rx[m] = 8'h00;
      end else begin
        if (!ready[m]) busy[m]++;
        if (done[m])   done_cnt[m]++;
        if (!ldac[m])  ldac_low[m]++;
        if (!cs[m]) begin
          if (prev_cs[m]) begin
            if (nframes[m] > 0) gap_len[m] = hi_run[m];
            cs_run[m] = 0; rx_bits[m] = 0; rx[m] = 8'h00;
          end
          cs_run[m]++;
          if (sclk[m] != prev_sclk[m] && is_sample_edge(m, sclk[m])) begin
            rx[m] = {rx[m][6:0], sdo[m]};
            rx_bits[m]++;
          end
        end else begin
          if (!prev_cs[m]) begin
            if (nframes[m] < 4) begin
              fword[m][nframes[m]] = rx[m];
              flen[m][nframes[m]]  = cs_run[m];
              fbits[m][nframes[m]] = rx_bits[m];
            end
            nframes[m]++;
            hi_run[m] = 0;
          end
          hi_run[m]++;
          if (sdo[m]) sdo_bad[m]++;
          if (sclk[m] != (m >= 2)) idle_bad[m]++;
          if (sclk[m] != prev_sclk[m]) glitch_bad[m]++;
        end
      end
      prev_sclk[m] = sclk[m];
      prev_cs[m]   = cs[m];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] mk);
    @(posedge clk); #1;
    mon_clear = 1'b1; data = d; mask = mk; send_req = 1'b1;
    @(posedge clk); #1;
    mon_clear = 1'b0; send_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (ready != 4'hF && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_clean(input string tag);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_idle_clk_m%0d", tag, m), idle_bad[m], 0);
      check($sformatf("%s_glitch_m%0d", tag, m), glitch_bad[m], 0);
      check($sformatf("%s_sdo_idle_m%0d", tag, m), sdo_bad[m], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; data = '0; mask = '0; send_req = 1'b0; mon_clear = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_cs", cs, 4'hF);
    check("rst_sclk", sclk, 4'b1100);
    check("rst_sdo", sdo, 4'h0);
    check("rst_ldac", ldac, 4'hF);
    check("rst_ready", ready, 4'hF);
    check("rst_done", done, 4'h0);
    rst = 1'b0;

    // Single frame on channel 0.
    send(16'h00A5, 2'b01);
    check("t1_ready_low", ready, 4'h0);
    wait_idle(200);
    check("t1_frames", nframes[2], 1);
    check("t1_word", fword[2][0], 8'hA5);
    check("t1_bits", fbits[2][0], 8);
    check("t1_cs_len", flen[2][0], 36);
    check("t1_ldac_len", ldac_low[2], 2);
    check("t1_done", done_cnt[2], 1);
    check("t1_busy", busy[2], 42);
    check_clean("t1");

    // Two frames, ascending channel order, one LDAC.
    send(16'hC33C, 2'b11);
    wait_idle(300);
    check("t2_frames", nframes[2], 2);
    check("t2_word0", fword[2][0], 8'h3C);
    check("t2_word1", fword[2][1], 8'hC3);
    check("t2_cs_len1", flen[2][1], 36);
    check("t2_gap", gap_len[2], 4);
    check("t2_ldac_len", ldac_low[2], 2);
    check("t2_done", done_cnt[2], 1);
    check("t2_busy", busy[2], 82);

    // All four SPI modes decode the same word.
    send(16'h0081, 2'b01);
    wait_idle(200);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("t3_word_m%0d", m), fword[m][0], 8'h81);
      check($sformatf("t3_bits_m%0d", m), fbits[m][0], 8);
    end
    check_clean("t3");

    // Only channel 1 enabled.
    send(16'h5AFF, 2'b10);
    wait_idle(200);
    check("t4_frames", nframes[2], 1);
    check("t4_word", fword[2][0], 8'h5A);
    check("t4_word_m1", fword[1][0], 8'h5A);

    // Empty mask is ignored.
    send(16'h1234, 2'b00);
    check("t5_ready_stays", ready, 4'hF);
    repeat (20) @(negedge clk);
    check("t5_busy", busy[2], 0);
    check("t5_frames", nframes[2], 0);
    check("t5_done", done_cnt[2], 0);

    // A request while busy must not disturb the words in flight.
    send(16'hC33C, 2'b11);
    repeat (20) @(posedge clk); #1;
    data = 16'hFFFF; mask = 2'b11; send_req = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
    wait_idle(300);
    check("t6_frames", nframes[2], 2);
    check("t6_word0", fword[2][0], 8'h3C);
    check("t6_word1", fword[2][1], 8'hC3);
    check("t6_done", done_cnt[2], 1);
    check("t6_busy", busy[2], 82);

    // Reset in the middle of bit 4 of the first frame.
    send(16'hC3A5, 2'b11);
    repeat (18) @(posedge clk); #1;
    check("t7_cs_before", cs, 4'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t7_cs", cs, 4'hF);
    check("t7_sclk", sclk, 4'b1100);
    check("t7_sdo", sdo, 4'h0);
    check("t7_ldac", ldac, 4'hF);
    check("t7_ready", ready, 4'hF);
    check("t7_done", done, 4'h0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t7_no_done", done_cnt[2], 0);
    check("t7_no_ldac", ldac_low[2], 0);
    check("t7_frames", nframes[2], 1);
    check("t7_ready_after", ready, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
